// File: rtl/cordic_range_ctrl_if.sv
// Bundle between the CORDIC range controller, its angle source, the CORDIC core and the result consumer.
// out_err exists only when CORDIC_TIMEOUT_EN is defined.
interface cordic_range_ctrl_if #(
  parameter int DATA_W = 18
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W:0]   in_angle;
  logic signed [DATA_W-1:0] cordic_angle;
  logic                     cordic_init;
  logic                     cordic_done;
  logic signed [DATA_W-1:0] cordic_cos;
  logic signed [DATA_W-1:0] cordic_sin;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_cos;
  logic signed [DATA_W-1:0] out_sin;
`ifdef CORDIC_TIMEOUT_EN
  logic                     out_err;
`endif

  modport master (
`ifdef CORDIC_TIMEOUT_EN
    output out_err,
`endif
    output in_ready, cordic_angle, cordic_init, out_valid, out_cos, out_sin,
    input  in_valid, in_angle, cordic_done, cordic_cos, cordic_sin, out_ready
  );

  modport slave (
`ifdef CORDIC_TIMEOUT_EN
    input  out_err,
`endif
    input  in_ready, cordic_angle, cordic_init, out_valid, out_cos, out_sin,
    output in_valid, in_angle, cordic_done, cordic_cos, cordic_sin, out_ready
  );
endinterface

// File: rtl/cordic_range_ctrl.sv
// Folds an angle in [-pi, pi) into the CORDIC convergence range, runs the core, and sign-corrects its result.
// Optional macro CORDIC_TIMEOUT_EN adds a WAIT timeout that returns zero data with out_err set.
module cordic_range_ctrl #(
  parameter int DATA_W           = 18,
  parameter int PI_Q             = 205887,
  parameter int HALF_PI_Q        = 102944,
  parameter int DONE_MASK_CYCLES = 2,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input logic               clk,
  input logic               reset,
  cordic_range_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(DONE_MASK_CYCLES + TIMEOUT_CYCLES + 1);
  localparam logic signed [DATA_W:0] C_PI      = PI_Q[DATA_W:0];
  localparam logic signed [DATA_W:0] C_HALF_PI = HALF_PI_Q[DATA_W:0];
  localparam logic [CNT_W-1:0]       C_MASK    = CNT_W'(DONE_MASK_CYCLES);
`ifdef CORDIC_TIMEOUT_EN
  localparam logic [CNT_W-1:0]       C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic signed [DATA_W-1:0] r_angle;
  logic                     r_flip;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [DATA_W-1:0] r_cos;
  logic signed [DATA_W-1:0] r_sin;
  logic                     w_accept;
  logic                     w_capture;
  logic                     w_timeout;
  logic                     w_done_ok;
  logic                     w_flip;
  logic signed [DATA_W-1:0] w_reduced;
`ifdef CORDIC_TIMEOUT_EN
  logic                     r_err;
`endif

  // Reduction is done at full input width; the folded result always fits the core's narrower port.
  function automatic logic signed [DATA_W-1:0] f_fold(input logic signed [DATA_W:0] a);
    logic signed [DATA_W:0] t;
    if (a > C_HALF_PI)       t = a - C_PI;
    else if (a < -C_HALF_PI) t = a + C_PI;
    else                     t = a;
    return t[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] f_cond_neg(input logic signed [DATA_W-1:0] x,
                                                          input logic neg);
    return neg ? -x : x;
  endfunction

  assign w_flip    = (bus.in_angle > C_HALF_PI) || (bus.in_angle < -C_HALF_PI);
  assign w_reduced = f_fold(bus.in_angle);
  // A done within the mask window is a leftover from the previous operation.
  assign w_done_ok = bus.cordic_done && (r_cnt >= C_MASK);

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.in_valid) begin
                 w_accept = 1'b1;
                 w_next   = S_ISSUE;
               end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done_ok) begin
                 w_capture = 1'b1;
                 w_next    = S_OUT;
               end
`ifdef CORDIC_TIMEOUT_EN
               else if (r_cnt == C_TO_LAST) begin
                 w_timeout = 1'b1;
                 w_next    = S_OUT;
               end
`endif
      S_OUT:   if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_angle <= '0;
      r_flip  <= 1'b0;
      r_cnt   <= '0;
      r_cos   <= '0;
      r_sin   <= '0;
`ifdef CORDIC_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_angle <= w_reduced;
        r_flip  <= w_flip;
      end
      if (r_state != S_WAIT)  r_cnt <= '0;
      else if (r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
      if (w_capture) begin
        r_cos <= f_cond_neg(bus.cordic_cos, r_flip);
        r_sin <= f_cond_neg(bus.cordic_sin, r_flip);
      end else if (w_timeout) begin
        r_cos <= '0;
        r_sin <= '0;
      end
`ifdef CORDIC_TIMEOUT_EN
      if (w_timeout)                                 r_err <= 1'b1;
      else if (r_state == S_OUT && bus.out_ready)    r_err <= 1'b0;
`endif
    end
  end

  assign bus.in_ready     = (r_state == S_IDLE);
  assign bus.cordic_init  = (r_state == S_ISSUE);
  assign bus.cordic_angle = r_angle;
  assign bus.out_valid    = (r_state == S_OUT);
  assign bus.out_cos      = r_cos;
  assign bus.out_sin      = r_sin;
`ifdef CORDIC_TIMEOUT_EN
  assign bus.out_err      = r_err;
`endif

endmodule

// File: tb/tb_cordic_range_ctrl.sv
// Bench for cordic_range_ctrl: a trigonometric reference on the unfolded angle, an ideal core model,
// directed boundary/handshake/reset scenarios and a randomized sweep.
module tb_cordic_range_ctrl;
  localparam int PI_Q = 205887;
  localparam int HALF = 102944;
  localparam int MASK = 2;
  localparam int TO   = 64;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cordic_range_ctrl_if #(.DATA_W(18)) bus ();

  cordic_range_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic int q16(input real r);
    return int'(r * 65536.0);
  endfunction

  function automatic int exp_reduced(input int a);
    if (a > HALF)  return a - PI_Q;
    if (a < -HALF) return a + PI_Q;
    return a;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One full operation. fixed=1 makes the core return fsin/fcos and expects them exactly.
  task automatic run_op(input int ang, input int dly, input int hold, input bit fixed,
                        input int fsin, input int fcos, input string nm);
    int    c;
    int    exp_edges;
    int    ecos;
    int    esin;
    int    csin;
    int    ccos;
    logic signed [17:0] snap_cos;
    logic signed [17:0] snap_sin;
    real   a;

    c = 0;
    while (bus.in_ready !== 1'b1 && c < 50) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_wait in_ready=%b expected 1", nm, bus.in_ready);
    end

    bus.in_valid = 1'b1;
    bus.in_angle = 19'(ang);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    checks++;
    if (bus.cordic_init !== 1'b1 || bus.cordic_angle !== 18'(exp_reduced(ang)) || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s issue init=%b angle=%0d ready=%b expected init=1 angle=%0d ready=0",
               nm, bus.cordic_init, bus.cordic_angle, bus.in_ready, exp_reduced(ang));
    end

    if (dly == 0) begin
      bus.cordic_done = 1'b1;
      bus.cordic_cos  = 18'(12345);
      bus.cordic_sin  = 18'(-777);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.cordic_init !== 1'b0) begin
      errors++; $display("FAIL %s init_one_cycle init=%b expected 0", nm, bus.cordic_init);
    end

    if (fixed) begin
      csin = fsin; ccos = fcos;
    end else begin
      a    = real'(bus.cordic_angle) / 65536.0;
      csin = q16($sin(a));
      ccos = q16($cos(a));
    end

    c = 0;
    while (bus.out_valid !== 1'b1 && c < 200) begin
      bus.cordic_done = (c >= dly);
      if (c >= dly && c >= MASK) begin
        bus.cordic_cos = 18'(ccos);
        bus.cordic_sin = 18'(csin);
      end else begin
        bus.cordic_cos = 18'(12345);
        bus.cordic_sin = 18'(-777);
      end
      @(posedge clk); #1; c++;
    end
    bus.cordic_done = 1'b0;
    bus.cordic_cos  = 18'(-4321);
    bus.cordic_sin  = 18'(999);

    exp_edges = ((dly > MASK) ? dly : MASK) + 1;
    checks++;
    if (c != exp_edges) begin
      errors++; $display("FAIL %s latency wait_cycles=%0d expected %0d", nm, c, exp_edges);
    end

    if (fixed) begin
      ecos = fcos; esin = fsin;
    end else begin
      ecos = q16($cos(real'(ang) / 65536.0));
      esin = q16($sin(real'(ang) / 65536.0));
    end
    checks++;
    if (iabs(int'(bus.out_cos) - ecos) > (fixed ? 0 : 2) ||
        iabs(int'(bus.out_sin) - esin) > (fixed ? 0 : 2)) begin
      errors++;
      $display("FAIL %s result cos=%0d sin=%0d expected cos=%0d sin=%0d", nm,
               bus.out_cos, bus.out_sin, ecos, esin);
    end
`ifdef CORDIC_TIMEOUT_EN
    checks++;
    if (bus.out_err !== 1'b0) begin
      errors++; $display("FAIL %s out_err=%b expected 0", nm, bus.out_err);
    end
`endif

    snap_cos = bus.out_cos;
    snap_sin = bus.out_sin;
    bus.in_valid = (hold > 0);
    bus.in_angle = 19'(1234);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_cos !== snap_cos || bus.out_sin !== snap_sin) begin
        errors++;
        $display("FAIL %s backpressure valid=%b ready=%b cos=%0d sin=%0d expected 1 0 %0d %0d",
                 nm, bus.out_valid, bus.in_ready, bus.out_cos, bus.out_sin, snap_cos, snap_sin);
      end
    end

    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake valid=%b ready=%b expected valid=0 ready=1",
               nm, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.cordic_angle !== 18'd0 || bus.cordic_init !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_cos !== 18'd0 || bus.out_sin !== 18'd0) begin
      errors++;
      $display("FAIL reset_state angle=%0d init=%b valid=%b cos=%0d sin=%0d expected all 0",
               bus.cordic_angle, bus.cordic_init, bus.out_valid, bus.out_cos, bus.out_sin);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready in_ready=%b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    run_op(32768,   3, 0, 1'b1, 31419, 57512, "half_rad");
    run_op(163840,  4, 1, 1'b0, 0, 0, "2p5_rad");
    run_op(-196608, 2, 0, 1'b0, 0, 0, "m3_rad");
  endtask

  task automatic test_boundaries();
    run_op(102944,  3, 0, 1'b0, 0, 0, "half_pi");
    run_op(102945,  3, 0, 1'b0, 0, 0, "above_half_pi");
    run_op(-102945, 3, 0, 1'b0, 0, 0, "below_m_half_pi");
    run_op(-102944, 3, 0, 1'b0, 0, 0, "m_half_pi");
    run_op(-205887, 3, 0, 1'b0, 0, 0, "minus_pi");
    run_op(205886,  3, 0, 1'b0, 0, 0, "max_angle");
  endtask

  task automatic test_stale_done();
    run_op(-50000, 0, 0, 1'b0, 0, 0, "stale_done");
    run_op(150000, 1, 0, 1'b0, 0, 0, "stale_done_d1");
  endtask

  task automatic test_backpressure();
    run_op(70000, 5, 5, 1'b0, 0, 0, "hold5");
  endtask

  task automatic test_reset_mid_op();
    bus.in_valid = 1'b1;
    bus.in_angle = 19'(180000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.cordic_angle !== 18'd0 || bus.cordic_init !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_cos !== 18'd0 || bus.out_sin !== 18'd0) begin
      errors++;
      $display("FAIL reset_wait angle=%0d init=%b valid=%b cos=%0d sin=%0d expected all 0",
               bus.cordic_angle, bus.cordic_init, bus.out_valid, bus.out_cos, bus.out_sin);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.cordic_done = 1'b1;
    bus.cordic_cos  = 18'(500);
    bus.cordic_sin  = 18'(600);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    bus.cordic_done = 1'b0;
    run_op(-120000, 3, 0, 1'b0, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    int ang;
    for (int i = 0; i < 24; i++) begin
      ang = int'($urandom_range(411773, 0)) - PI_Q;
      run_op(ang, int'($urandom_range(6, 0)), int'($urandom_range(2, 0)), 1'b0, 0, 0, "random");
    end
  endtask

`ifdef CORDIC_TIMEOUT_EN
  task automatic test_timeout();
    int c;
    bus.in_valid = 1'b1;
    bus.in_angle = 19'(40000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    c = 0;
    while (bus.out_valid !== 1'b1 && c < 200) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (c != TO || bus.out_err !== 1'b1 || bus.out_cos !== 18'd0 || bus.out_sin !== 18'd0) begin
      errors++;
      $display("FAIL timeout cycles=%0d err=%b cos=%0d sin=%0d expected cycles=%0d err=1 cos=0 sin=0",
               c, bus.out_err, bus.out_cos, bus.out_sin, TO);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_err !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_clear err=%b valid=%b expected 0 0", bus.out_err, bus.out_valid);
    end
  endtask
`endif

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_angle    = '0;
    bus.cordic_done = 1'b0;
    bus.cordic_cos  = '0;
    bus.cordic_sin  = '0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_directed();
    test_boundaries();
    test_stale_done();
    test_backpressure();
    test_reset_mid_op();
    test_random();
`ifdef CORDIC_TIMEOUT_EN
    test_timeout();
    run_op(90000, 3, 0, 1'b0, 0, 0, "after_timeout");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
